// File: rtl/ebreak_drain_ctrl_pkg.sv
// Shared types for the ebreak drain controller: FSM states and a timer-width helper.
package ebreak_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIRE  = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // A TIMEOUT of 1 still needs a one-bit timer.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ebreak_drain_ctrl_if.sv
// Commit/AXI-event inputs and monitor-facing outputs of the ebreak drain controller.
interface ebreak_drain_ctrl_if #(
    parameter int DATA_LEN = 32
);
    logic                commit_valid;
    logic                commit_ebreak;
    logic [DATA_LEN-1:0] commit_pc;
    logic [DATA_LEN-1:0] commit_a0;
    logic                aw_fire;
    logic                b_fire;
    logic                ifu_stall;
    logic                ebreak;
    logic [DATA_LEN-1:0] halt_pc;
    logic [DATA_LEN-1:0] halt_code;
    logic                drain_timeout;
    logic                bus_err;

    modport master (
        output commit_valid, commit_ebreak, commit_pc, commit_a0, aw_fire, b_fire,
        input  ifu_stall, ebreak, halt_pc, halt_code, drain_timeout, bus_err
    );

    modport slave (
        input  commit_valid, commit_ebreak, commit_pc, commit_a0, aw_fire, b_fire,
        output ifu_stall, ebreak, halt_pc, halt_code, drain_timeout, bus_err
    );
endinterface

// File: rtl/ebreak_drain_ctrl_outs_counter.sv
// Saturating count of AXI writes still awaiting their B response, with sticky protocol-error flag.
module ebreak_drain_ctrl_outs_counter
    import ebreak_drain_ctrl_pkg::*;
#(
    parameter int OUTS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aw_fire,
    input  logic              b_fire,
    output logic [OUTS_W-1:0] count,
    output logic              bus_err
);

    localparam logic [OUTS_W-1:0] COUNT_MAX = {OUTS_W{1'b1}};

    // Simultaneous AW and B cancel out; underflow and overflow hold the count and flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            bus_err <= 1'b0;
        end else if (aw_fire && !b_fire) begin
            if (count == COUNT_MAX) begin
                bus_err <= 1'b1;
            end else begin
                count <= count + OUTS_W'(1);
            end
        end else if (b_fire && !aw_fire) begin
            if (count == '0) begin
                bus_err <= 1'b1;
            end else begin
                count <= count - OUTS_W'(1);
            end
        end
    end

endmodule

// File: rtl/ebreak_drain_ctrl.sv
// Holds fetch on a committed ebreak, waits for all AXI writes to complete, then pulses ebreak
// to the simulation monitor with the latched halt PC and exit code.
module ebreak_drain_ctrl
    import ebreak_drain_ctrl_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int OUTS_W   = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ebreak_drain_ctrl_if.slave   bus
);

    localparam int             TW         = timer_width(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    drain_state_t        state;
    logic [TW-1:0]       timer;
    logic [OUTS_W-1:0]   count;
    logic                bus_err;
    logic                stall_q;
    logic                ebreak_q;
    logic                timeout_q;
    logic [DATA_LEN-1:0] halt_pc_q;
    logic [DATA_LEN-1:0] halt_code_q;

    ebreak_drain_ctrl_outs_counter #(
        .OUTS_W (OUTS_W)
    ) u_outs_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .aw_fire (bus.aw_fire),
        .b_fire  (bus.b_fire),
        .count   (count),
        .bus_err (bus_err)
    );

    // Drain is complete only when nothing is outstanding and no write event is in flight this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            timer       <= '0;
            stall_q     <= 1'b0;
            ebreak_q    <= 1'b0;
            timeout_q   <= 1'b0;
            halt_pc_q   <= '0;
            halt_code_q <= '0;
        end else begin
            ebreak_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (bus.commit_valid && bus.commit_ebreak) begin
                        halt_pc_q   <= bus.commit_pc;
                        halt_code_q <= bus.commit_a0;
                        stall_q     <= 1'b1;
                        timer       <= '0;
                        state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    timer <= timer + TW'(1);
                    if (count == '0 && !bus.aw_fire && !bus.b_fire) begin
                        ebreak_q <= 1'b1;
                        state    <= ST_FIRE;
                    end else if (timer == TIMER_LAST) begin
                        ebreak_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.ifu_stall     = stall_q;
    assign bus.ebreak        = ebreak_q;
    assign bus.halt_pc       = halt_pc_q;
    assign bus.halt_code     = halt_code_q;
    assign bus.drain_timeout = timeout_q;
    assign bus.bus_err       = bus_err;

endmodule

// File: tb/tb_ebreak_drain_ctrl.sv
// Scoreboard bench for ebreak_drain_ctrl: directed and random scenarios against a cycle-schedule model.
module tb_ebreak_drain_ctrl;

    localparam int TIMEOUT = 16;
    localparam int OUTS_W  = 4;
    localparam int CNT_MAX = 15;
    localparam int MAXC    = 8192;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] code;
        bit          to;
    } pulse_t;

    logic clk;
    logic rst_n;
    ebreak_drain_ctrl_if #(.DATA_LEN(32)) bus ();

    ebreak_drain_ctrl #(
        .DATA_LEN (32),
        .OUTS_W   (OUTS_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    bit          exp_stall [MAXC];
    bit          exp_err   [MAXC];
    pulse_t      exp_q [$];

    bit          sc_cv [$];
    bit          sc_ce [$];
    bit          sc_aw [$];
    bit          sc_b  [$];
    logic [31:0] sc_pc [$];
    logic [31:0] sc_a0 [$];
    int          sc_abort;

    logic [31:0] end_pc;
    logic [31:0] end_code;
    bit          end_to;
    bit          end_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every cycle and retires a scoreboard entry whenever a pulse is due.
    always @(negedge clk) begin
        bit due;
        if (cyc < MAXC) begin
            check_output("ifu_stall", {31'd0, bus.ifu_stall}, {31'd0, exp_stall[cyc]});
            check_output("bus_err", {31'd0, bus.bus_err}, {31'd0, exp_err[cyc]});
        end
        due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check_output("ebreak", {31'd0, bus.ebreak}, {31'd0, due});
        if (due) begin
            check_output("halt_pc", bus.halt_pc, exp_q[0].pc);
            check_output("halt_code", bus.halt_code, exp_q[0].code);
            check_output("drain_timeout", {31'd0, bus.drain_timeout}, {31'd0, exp_q[0].to});
            void'(exp_q.pop_front());
        end
    end

    task automatic clear_sc();
        sc_cv.delete(); sc_ce.delete(); sc_aw.delete(); sc_b.delete();
        sc_pc.delete(); sc_a0.delete();
        sc_abort = -1;
    endtask

    task automatic add_cycle(input bit cv, input bit ce, input bit aw, input bit b,
                             input logic [31:0] pc, input logic [31:0] a0);
        sc_cv.push_back(cv); sc_ce.push_back(ce); sc_aw.push_back(aw); sc_b.push_back(b);
        sc_pc.push_back(pc); sc_a0.push_back(a0);
    endtask

    task automatic add_idle();
        add_cycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic pad_to(input int n);
        while (sc_cv.size() < n) add_idle();
    endtask

    // Reference: count per cycle from the write schedule, then scan drain cycles for the halt rule.
    task automatic compute_expect(input int base);
        int n;
        int c;
        int cnt;
        int lim;
        int p;
        bit err;
        bit to;
        int cnt_at [$];
        n   = sc_cv.size();
        c   = -1;
        cnt = 0;
        err = 1'b0;
        lim = (sc_abort >= 0) ? sc_abort : n;
        for (int i = 0; i < n; i++) begin
            if (c < 0 && sc_cv[i] && sc_ce[i]) c = i;
            cnt_at.push_back(cnt);
            if (i < lim && base + i < MAXC) exp_err[base + i] = err;
            if (sc_aw[i] && !sc_b[i]) begin
                if (cnt == CNT_MAX) err = 1'b1; else cnt++;
            end else if (sc_b[i] && !sc_aw[i]) begin
                if (cnt == 0) err = 1'b1; else cnt--;
            end
        end
        p  = -1;
        to = 1'b0;
        for (int d = c + 1; d < n; d++) begin
            if (cnt_at[d] == 0 && !sc_aw[d] && !sc_b[d]) begin
                p = d + 1;
                break;
            end
            if (d - (c + 1) == TIMEOUT - 1) begin
                p  = d + 1;
                to = 1'b1;
                break;
            end
        end
        for (int i = c + 1; i < lim; i++) begin
            if (base + i < MAXC) exp_stall[base + i] = 1'b1;
        end
        if (sc_abort < 0 && p >= 0) begin
            pulse_t e;
            e.cyc  = base + p;
            e.pc   = sc_pc[c];
            e.code = sc_a0[c];
            e.to   = to;
            exp_q.push_back(e);
        end
        end_pc   = sc_pc[c];
        end_code = sc_a0[c];
        end_to   = to;
        end_err  = err;
    endtask

    task automatic drive_idle();
        bus.commit_valid  = 1'b0;
        bus.commit_ebreak = 1'b0;
        bus.commit_pc     = '0;
        bus.commit_a0     = '0;
        bus.aw_fire       = 1'b0;
        bus.b_fire        = 1'b0;
    endtask

    task automatic apply_stimulus();
        int  base;
        bit  aborted;
        drive_idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        base    = cyc;
        aborted = 1'b0;
        compute_expect(base);
        for (int i = 0; i < sc_cv.size(); i++) begin
            bus.commit_valid  = sc_cv[i];
            bus.commit_ebreak = sc_ce[i];
            bus.commit_pc     = sc_pc[i];
            bus.commit_a0     = sc_a0[i];
            bus.aw_fire       = sc_aw[i];
            bus.b_fire        = sc_b[i];
            if (i == sc_abort) begin
                #2 rst_n = 1'b0;
                #1;
                check_output("rst_ifu_stall", {31'd0, bus.ifu_stall}, 32'd0);
                check_output("rst_ebreak", {31'd0, bus.ebreak}, 32'd0);
                check_output("rst_halt_pc", bus.halt_pc, 32'd0);
                check_output("rst_halt_code", bus.halt_code, 32'd0);
                check_output("rst_drain_timeout", {31'd0, bus.drain_timeout}, 32'd0);
                check_output("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        drive_idle();
        if (!aborted) begin
            check_output("pending_pulses", exp_q.size(), 32'd0);
            check_output("end_halt_pc", bus.halt_pc, end_pc);
            check_output("end_halt_code", bus.halt_code, end_code);
            check_output("end_drain_timeout", {31'd0, bus.drain_timeout}, {31'd0, end_to});
            check_output("end_bus_err", {31'd0, bus.bus_err}, {31'd0, end_err});
        end
        exp_q.delete();
    endtask

    task automatic build_random();
        int  commit_at;
        int  len;
        int  cnt;
        bit  cv, ce, aw, b;
        clear_sc();
        commit_at = $urandom_range(0, 6);
        len       = commit_at + TIMEOUT + 4;
        cnt       = 0;
        for (int i = 0; i < len; i++) begin
            cv = $urandom_range(0, 1);
            ce = $urandom_range(0, 1);
            if (i < commit_at && cv) ce = 1'b0;
            if (i == commit_at) begin cv = 1'b1; ce = 1'b1; end
            if (i <= commit_at) begin
                aw = ($urandom_range(0, 1) == 0);
                b  = ($urandom_range(0, 3) == 0);
            end else begin
                aw = ($urandom_range(0, 5) == 0);
                b  = ($urandom_range(0, 1) == 0);
            end
            if (b && cnt == 0) b = 1'b0;
            if (aw && !b && cnt == CNT_MAX) aw = 1'b0;
            if (aw && !b) cnt++;
            if (b && !aw) cnt--;
            add_cycle(cv, ce, aw, b, $urandom, $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();

        $display("[TB] idle ebreak");
        clear_sc();
        add_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h1111_0000, 32'h5);
        add_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h2222_0000, 32'h6);
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0);
        pad_to(2 + TIMEOUT + 4);
        apply_stimulus();

        $display("[TB] outstanding stores");
        clear_sc();
        repeat (3) add_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0100, 32'h2A);
        pad_to(3 + TIMEOUT + 4);
        sc_b[8] = 1'b1; sc_b[9] = 1'b1; sc_b[12] = 1'b1;
        apply_stimulus();

        $display("[TB] simultaneous aw and b in drain");
        clear_sc();
        add_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h7);
        pad_to(1 + TIMEOUT + 4);
        sc_aw[4] = 1'b1; sc_b[4] = 1'b1; sc_b[8] = 1'b1;
        apply_stimulus();

        $display("[TB] drain timeout");
        clear_sc();
        add_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0300, 32'h1);
        pad_to(1 + TIMEOUT + 4);
        apply_stimulus();

        $display("[TB] b_fire with nothing outstanding");
        clear_sc();
        add_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        add_idle();
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0400, 32'h3);
        pad_to(2 + TIMEOUT + 4);
        apply_stimulus();

        $display("[TB] commits after ebreak are ignored");
        clear_sc();
        add_idle();
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0500, 32'h9);
        pad_to(1 + TIMEOUT + 4);
        sc_cv[2] = 1'b1; sc_ce[2] = 1'b1;
        sc_cv[4] = 1'b1; sc_ce[4] = 1'b1;
        sc_cv[6] = 1'b1; sc_ce[6] = 1'b1;
        apply_stimulus();

        $display("[TB] counter saturation");
        clear_sc();
        repeat (16) add_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0600, 32'h4);
        pad_to(36);
        for (int i = 17; i < 32; i++) sc_b[i] = 1'b1;
        apply_stimulus();

        $display("[TB] reset mid-drain");
        clear_sc();
        add_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0700, 32'h8);
        pad_to(20);
        sc_abort = 5;
        apply_stimulus();

        clear_sc();
        add_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0);
        pad_to(TIMEOUT + 4);
        apply_stimulus();

        $display("[TB] random scenarios");
        for (int s = 0; s < 40; s++) begin
            build_random();
            apply_stimulus();
        end

        rst_n = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
